// File: rtl/codec_cfg_sequencer_pkg.sv
// codec_cfg_pkg: sequencer states, codec register addresses and the power-up write table.
package codec_cfg_pkg;

    typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, GAP, DONE, ERROR} state_e;

    localparam logic [6:0] WM_REG_RESET  = 7'h0F;
    localparam logic [6:0] WM_REG_ACTIVE = 7'h09;

    // Entry 0 soft-resets the codec; the last entry activates the digital interface.
    function automatic logic [15:0] cfg_entry(input logic [3:0] index);
        logic [15:0] e;
        case (index)
            4'd0:    e = {WM_REG_RESET, 9'h000};
            4'd1:    e = {7'h00, 9'h017};
            4'd2:    e = {7'h01, 9'h017};
            4'd3:    e = {7'h02, 9'h079};
            4'd4:    e = {7'h03, 9'h079};
            4'd5:    e = {7'h04, 9'h012};
            4'd6:    e = {7'h05, 9'h000};
            4'd7:    e = {7'h06, 9'h000};
            4'd8:    e = {7'h07, 9'h001};
            4'd9:    e = {7'h08, 9'h000};
            4'd10:   e = {WM_REG_ACTIVE, 9'h001};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/codec_cfg_sequencer_if.sv
// codec_cfg_sequencer_if: request/done handshake towards the shared I2C master.
interface codec_cfg_sequencer_if;
    logic        i2c_req;
    logic [6:0]  i2c_dev;
    logic [15:0] i2c_data;
    logic        i2c_done;
    logic        i2c_nack;
    modport master (output i2c_req, i2c_dev, i2c_data, input i2c_done, i2c_nack);
    modport slave  (input i2c_req, i2c_dev, i2c_data, output i2c_done, i2c_nack);
endinterface

// File: rtl/codec_cfg_sequencer_timer.sv
// cfg_wait_timer: loadable down-counter that stops at zero; used for write gaps and the ack watchdog.
module cfg_wait_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero
);
    assign zero = count == '0;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && !zero)
            count <= count - 1'b1;
    end
endmodule

// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer: walks the codec power-up register table over the shared I2C master.
// Defining CODEC_CFG_TIMEOUT_EN adds a 2^20-cycle ack watchdog and the timeout_flag output.
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int         NUM_REGS   = 11,
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         RESET_WAIT = 1000,
    parameter int         GAP_WAIT   = 100,
    parameter int         MAX_RETRY  = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    codec_cfg_sequencer_if.master        i2c,
    output logic                         busy,
    output logic                         cfg_done,
    output logic                         cfg_error,
    output logic [3:0]                   cur_index
`ifdef CODEC_CFG_TIMEOUT_EN
    ,
    output logic                         timeout_flag
`endif
);
`ifdef CODEC_CFG_TIMEOUT_EN
    localparam int TW = 20;
`else
    localparam int TW = 16;
`endif
    localparam int             RTW       = $clog2(MAX_RETRY + 1);
    localparam logic [RTW-1:0] RMAX      = RTW'(MAX_RETRY);
    localparam logic [3:0]     LAST      = 4'(NUM_REGS - 1);
    localparam logic [15:0]    RW16      = 16'(RESET_WAIT);
    localparam logic [15:0]    GW16      = 16'(GAP_WAIT);
    localparam logic [TW-1:0]  RESET_LEN = TW'(RW16 == 16'd0 ? 16'd1 : RW16);
    localparam logic [TW-1:0]  GAP_LEN   = TW'(GW16 == 16'd0 ? 16'd1 : GW16);

    state_e         state;
    logic [3:0]     index;
    logic [RTW-1:0] retry;
    logic           again;
    logic           timeout;
    logic           fin;
    logic           fail;
    logic           t_load;
    logic           t_zero;
    logic           gap_end;
    logic [TW-1:0]  t_val;
    logic [TW-1:0]  t_count;

    cfg_wait_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .en       (state == GAP || state == WAIT_ACK),
        .count    (t_count),
        .zero     (t_zero)
    );

`ifdef CODEC_CFG_TIMEOUT_EN
    assign timeout = !i2c.i2c_done && t_zero;
`else
    assign timeout = 1'b0;
`endif
    assign fin     = i2c.i2c_done || timeout;
    assign fail    = i2c.i2c_nack || timeout;
    assign gap_end = t_zero || t_count == TW'(1);
    // SEND arms the watchdog; a finished transaction reloads the timer for the following gap.
    // A retry also passes through a one-cycle GAP so that i2c_req drops between attempts.
    assign t_load  = state == SEND || (state == WAIT_ACK && fin);
    assign t_val   = state == SEND ? '1 : fail ? TW'(1) : index == 4'd0 ? RESET_LEN : GAP_LEN;

    assign i2c.i2c_req  = state == SEND || state == WAIT_ACK;
    assign i2c.i2c_dev  = DEV_ADDR;
    assign i2c.i2c_data = i2c.i2c_req ? cfg_entry(index) : '0;
    assign busy         = i2c.i2c_req || state == GAP;
    assign cfg_done     = state == DONE;
    assign cfg_error    = state == ERROR;
    assign cur_index    = index;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            index <= '0;
            retry <= '0;
            again <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: if (start) begin
                    state <= SEND;
                    index <= '0;
                    retry <= '0;
                end
                SEND: state <= WAIT_ACK;
                WAIT_ACK: if (fin) begin
                    again <= fail;
                    state <= fail && retry == RMAX ? ERROR : GAP;
                    if (fail && retry != RMAX)
                        retry <= retry + 1'b1;
                end
                GAP: if (gap_end) begin
                    state <= again || index != LAST ? SEND : DONE;
                    if (!again && index != LAST) begin
                        index <= index + 1'b1;
                        retry <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CODEC_CFG_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset)
            timeout_flag <= 1'b0;
        else if (start && !busy)
            timeout_flag <= 1'b0;
        else if (state == WAIT_ACK && timeout)
            timeout_flag <= 1'b1;
    end
`endif
endmodule

// File: doc/codec_cfg_sequencer.md
Name: codec_cfg_sequencer

Overview:
- Sequences the audio codec's power-up register configuration over the shared I2C master channel.
- Walks a fixed table of 7-bit register / 9-bit value writes, issuing one write transaction per entry.
- Retries on NACK and inserts settle gaps between writes.
- Sits between system control (reset, buttons) and the I2C master, so sound_gen only sees a codec that is already configured.

Parameters:
- NUM_REGS, 11, number of table entries sent (1..11).
- DEV_ADDR, 7'h1A, codec I2C device address.
- RESET_WAIT, 1000, clk cycles held after entry 0 (codec soft reset) completes.
- GAP_WAIT, 100, clk cycles held after every other successful write.
- MAX_RETRY, 3, retries per entry after a NACK before declaring an error.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a configuration pass.
- i2c_req  out  1  transaction request; held high until i2c_done.
- i2c_dev  out  7  device address (constant DEV_ADDR).
- i2c_data  out  16  {reg_addr[6:0], reg_val[8:0]}; stable while i2c_req is high.
- i2c_done  in  1  one-cycle pulse; transaction finished.
- i2c_nack  in  1  qualifies i2c_done; 1 = transaction failed.
- busy  out  1  pass in progress.
- cfg_done  out  1  level; last pass completed successfully.
- cfg_error  out  1  level; last pass aborted.
- cur_index  out  4  table entry currently being sent.

Behaviour:
- Reset values: all outputs 0 except i2c_dev = DEV_ADDR; state = IDLE.
- States and transitions:
  - IDLE: start goes to SEND; index = 0; retry = 0; clears cfg_done and cfg_error.
  - SEND: drives i2c_req = 1 and i2c_data = table[index]; next cycle goes to WAIT_ACK.
  - WAIT_ACK: i2c_req stays 1; waits for i2c_done.
  - On i2c_done with nack = 0: i2c_req drops the next cycle; go to GAP with count = (index == 0 ? RESET_WAIT : GAP_WAIT).
  - On i2c_done with nack = 1 and retry < MAX_RETRY: retry++; go back to SEND.
  - On i2c_done with nack = 1 and retry == MAX_RETRY: go to ERROR.
  - GAP: count down to 1. If index == NUM_REGS-1 go to DONE; otherwise index++, retry = 0, go to SEND.
  - DONE: cfg_done = 1. ERROR: cfg_error = 1; cur_index holds the failing entry.
  - DONE and ERROR accept start exactly like IDLE (re-run).
- Latency:
  - start to i2c_req is 1 cycle.
  - i2c_done to the next i2c_req is the gap length + 1 cycle.
  - A NACK retry re-requests 2 cycles after i2c_done.
- busy = 1 in SEND, WAIT_ACK and GAP.
- start while busy is ignored.
- i2c_done outside WAIT_ACK is ignored.
- i2c_nack without i2c_done is ignored.
- Reset mid-transaction: i2c_req is low at the first clock edge with reset high, and the pass is abandoned. Re-run with start.
- Counters:
  - Gap counter is a 16-bit down-counter; a gap of 0 is treated as 1.
  - retry is $clog2(MAX_RETRY+1) bits wide.
- Configuration table (reg, val):
  - 0: 0F,000
  - 1: 00,017
  - 2: 01,017
  - 3: 02,079
  - 4: 03,079
  - 5: 04,012
  - 6: 05,000
  - 7: 06,000
  - 8: 07,001
  - 9: 08,000
  - 10: 09,001

Optional Feature:
- Macro CODEC_CFG_TIMEOUT_EN.
- With the macro defined:
  - A 20-bit watchdog runs in WAIT_ACK.
  - If 2^20 cycles pass without i2c_done, i2c_req drops and the event counts as a NACK (same retry/ERROR path).
  - Adds output timeout_flag (1 bit). It sets on any timeout and clears on start.
- Without the macro: WAIT_ACK waits indefinitely and the timeout_flag port is absent.

Decomposition:
- Package codec_cfg_pkg holds:
  - state enum: IDLE, SEND, WAIT_ACK, GAP, DONE, ERROR;
  - the register-table function cfg_entry(index) returning 16 bits;
  - constants WM_REG_RESET = 7'h0F and WM_REG_ACTIVE = 7'h09.
- One natural sub-module: cfg_wait_timer, a loadable down-counter with a zero flag. It is shared by GAP and the timeout watchdog.

Test Plan:
- Nominal pass: NUM_REGS = 11, RESET_WAIT = 8, GAP_WAIT = 2, bench acks every request after 5 cycles -> 11 requests in table order. First i2c_data = 16'h1E00 and last = 16'h1201. cfg_done rises; busy falls the same cycle.
- Single NACK: NACK on entry 3 once -> entry 3 re-requested 2 cycles after i2c_done, then index 4. cfg_done = 1, cfg_error = 0.
- Persistent NACK: entry 5 NACKs 4 times with MAX_RETRY = 3 -> exactly 4 requests for entry 5, then cfg_error = 1 and cur_index = 5. No further i2c_req.
- Mid-transaction reset: reset asserted during WAIT_ACK of entry 2 -> i2c_req = 0 and busy = 0 after the edge. A following start restarts at index 0 (i2c_data = 16'h1E00).
- Start while busy, plus a spurious i2c_done during GAP -> both ignored; request sequence and count are unchanged.
- With CODEC_CFG_TIMEOUT_EN: no i2c_done for entry 0 -> after 2^20 cycles timeout_flag = 1 and entry 0 is retried. After 4 timeouts, cfg_error = 1.
